winograd_dot_acc: RTL and testbench
===================================

// Module: winograd_dot_acc
// PURPOSE
//   Streaming Winograd fast-inner-product engine with multi-beat accumulation.
//   Each beat delivers 2*N_PAIRS activation/weight elements. The beat is reduced as
//   sum_p (a[2p+1]+b[2p])*(a[2p]+b[2p+1]), with optional correction to the exact dot product.
//   Beats accumulate until in_last_i. The group result is returned over a valid/ready output.
//   Generalises the fixed 8-element, two-output Winograd datapath: it adds pair count,
//   handshake, K-accumulation, exact mode and overflow reporting.
// PARAMETERS
//   IN_SIZE_0  8   signed activation width (a)
//   IN_SIZE_1  8   signed weight width (b)
//   N_PAIRS    4   pairs per beat (2*N_PAIRS elements per operand), >=1
//   ACC_SIZE   32  signed accumulator/result width; must be >= TERM_W=2*(max(IN_SIZE_0,IN_SIZE_1)+1)+$clog2(N_PAIRS) (elab $error otherwise)
//   BEAT_W     16  width of beat counter
// PORTS
//   clk_i        in   1                      clock, rising edge
//   rst_ni       in   1                      async active-low reset
//   in_valid_i   in   1                      beat valid
//   in_ready_o   out  1                      beat accepted when valid&ready
//   in_0_i       in   [0:2*N_PAIRS-1][IN_SIZE_0]  activations a, signed
//   in_1_i       in   [0:2*N_PAIRS-1][IN_SIZE_1]  weights b, signed
//   in_last_i    in   1                      beat closes the accumulation group
//   mode_i       in   1                      0=RAW Winograd sum, 1=EXACT (subtract a0*a1+b0*b1 per pair)
//   out_valid_o  out  1                      group result valid
//   out_ready_i  in   1                      result consumed when valid&ready
//   out_o        out  ACC_SIZE               signed group result
//   out_ovf_o    out  1                      signed overflow occurred in the group (result wrapped)
//   out_beats_o  out  BEAT_W                 beats in group, saturates at 2^BEAT_W-1
// BEHAVIOUR
//   - Reset: in_ready_o=1 after reset release, out_valid_o=0, out_o=0, out_ovf_o=0, out_beats_o=0; accumulator, beat count, stage valids cleared.
//   - Global enable en = !(out_valid_o && !out_ready_i); in_ready_o = en. All stages hold when en=0.
//   - S1 (accept edge N): register per-pair pre-sums (a[2p+1]+b[2p]) and (a[2p]+b[2p+1]), each max(IN)+1 bits.
//     Also register correction products a[2p]*a[2p+1] and b[2p]*b[2p+1]; last and mode travel with the beat.
//   - S2 (edge N+1): per-pair product minus corrections if mode=1; sign-extended adder-tree reduction to beat term.
//   - S3 (edge N+2): acc <= acc + term (two's complement wrap at ACC_SIZE); beat count +1.
//     If last: out_o <= acc+term, out_valid_o<=1, ovf/beats latched, then acc, count and ovf cleared for the next group.
//   - Latency: last beat accepted at edge N -> out_valid_o high after edge N+2, if not stalled.
//   - Back-to-back: one beat per cycle sustained. A new result may load on the same edge the previous one is consumed.
//   - Stall: out_valid_o=1 with out_ready_i=0 freezes out_o/out_ovf_o/out_beats_o and the whole pipe; in_ready_o=0.
//   - Overflow: sticky per group. Set when an S3 add changes sign incorrectly (both operands same sign, result differs).
//   - mode_i is sampled per beat; mixed modes within a group are legal and applied per beat.
//   - in_valid_i=0 inserts bubbles; the accumulator holds. A group with no last never emits a result.
//   - Reset mid-group: partial accumulation and in-flight beats discarded, no output.
//   - Sign extension of every operand before add/mul; no saturation anywhere except out_beats_o.
// TESTING (defaults unless stated)
//   1 EXACT, 1 beat last, all a=3 b=2 -> out_o=48, beats=1, ovf=0, out_valid 2 edges after accept.
//   2 RAW, same stimulus -> out_o=100 (4 pairs x 25).
//   3 EXACT, 3 beats a=b=-128, last on 3rd -> single result 393216, beats=3, ovf=0.
//   4 Backpressure: result pending, out_ready_i=0 for 5 cycles -> in_ready_o=0, outputs stable. Release -> next group result follows in order.
//   5 ACC_SIZE=20, EXACT, 4 beats a=b=-128 -> out_o=-524288 (wrapped), out_ovf_o=1. Next 1-beat group of ones -> 8, ovf=0.
//   6 2 beats (no last), rst_ni pulse, then 1 last beat a=b=1 EXACT -> out_o=8, beats=1. Plus 100 random groups vs. reference model.

Source files
------------

// File: rtl/winograd_dot_acc.sv
// Streaming Winograd inner-product engine: three-stage pipe (pre-sum, pair reduce, accumulate)
// with per-beat RAW/EXACT mode, multi-beat group accumulation and a valid/ready result port.
module winograd_dot_acc #(
  parameter int unsigned IN_SIZE_0 = 8,
  parameter int unsigned IN_SIZE_1 = 8,
  parameter int unsigned N_PAIRS   = 4,
  parameter int unsigned ACC_SIZE  = 32,
  parameter int unsigned BEAT_W    = 16
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  logic [0:2*N_PAIRS-1][IN_SIZE_0-1:0]    in_0_i,
  input  logic [0:2*N_PAIRS-1][IN_SIZE_1-1:0]    in_1_i,
  input  logic                                   in_last_i,
  input  logic                                   mode_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [ACC_SIZE-1:0]                    out_o,
  output logic                                   out_ovf_o,
  output logic [BEAT_W-1:0]                      out_beats_o
);

  localparam int unsigned MaxW  = (IN_SIZE_0 > IN_SIZE_1) ? IN_SIZE_0 : IN_SIZE_1;
  localparam int unsigned PsW   = MaxW + 1;
  localparam int unsigned TermW = 2 * PsW + $clog2(N_PAIRS);

  if (ACC_SIZE < TermW) begin : g_acc_size_check
    $error("winograd_dot_acc: ACC_SIZE must be >= %0d", TermW);
  end

  logic w_en;

  // S1 registers
  logic                     r_s1_valid;
  logic                     r_s1_last;
  logic                     r_s1_mode;
  logic signed [PsW-1:0]    r_s1_ps0 [N_PAIRS];
  logic signed [PsW-1:0]    r_s1_ps1 [N_PAIRS];
  logic signed [TermW-1:0]  r_s1_ca  [N_PAIRS];
  logic signed [TermW-1:0]  r_s1_cb  [N_PAIRS];

  // S2 registers
  logic                     r_s2_valid;
  logic                     r_s2_last;
  logic signed [TermW-1:0]  r_s2_term;

  // S3 / output registers
  logic signed [ACC_SIZE-1:0] r_acc;
  logic                       r_ovf;
  logic [BEAT_W-1:0]          r_beats;
  logic                       r_out_valid;
  logic [ACC_SIZE-1:0]        r_out;
  logic                       r_out_ovf;
  logic [BEAT_W-1:0]          r_out_beats;

  // A pending result that is not being taken freezes every stage.
  assign w_en        = !(r_out_valid && !out_ready_i);
  assign in_ready_o  = w_en;
  assign out_valid_o = r_out_valid;
  assign out_o       = r_out;
  assign out_ovf_o   = r_out_ovf;
  assign out_beats_o = r_out_beats;

  // ---------------------------------------------------------------------------------------------
  // S1: pre-sums and correction products
  // ---------------------------------------------------------------------------------------------
  logic signed [PsW-1:0]   w_ps0 [N_PAIRS];
  logic signed [PsW-1:0]   w_ps1 [N_PAIRS];
  logic signed [TermW-1:0] w_ca  [N_PAIRS];
  logic signed [TermW-1:0] w_cb  [N_PAIRS];

  for (genvar p = 0; p < N_PAIRS; p++) begin : g_s1
    logic signed [IN_SIZE_0-1:0] w_a0;
    logic signed [IN_SIZE_0-1:0] w_a1;
    logic signed [IN_SIZE_1-1:0] w_b0;
    logic signed [IN_SIZE_1-1:0] w_b1;

    assign w_a0 = in_0_i[2*p];
    assign w_a1 = in_0_i[2*p+1];
    assign w_b0 = in_1_i[2*p];
    assign w_b1 = in_1_i[2*p+1];

    assign w_ps0[p] = PsW'(w_a1) + PsW'(w_b0);
    assign w_ps1[p] = PsW'(w_a0) + PsW'(w_b1);
    assign w_ca[p]  = TermW'(w_a0) * TermW'(w_a1);
    assign w_cb[p]  = TermW'(w_b0) * TermW'(w_b1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_mode  <= 1'b0;
      for (int p = 0; p < N_PAIRS; p++) begin
        r_s1_ps0[p] <= '0;
        r_s1_ps1[p] <= '0;
        r_s1_ca[p]  <= '0;
        r_s1_cb[p]  <= '0;
      end
    end else if (w_en) begin
      r_s1_valid <= in_valid_i;
      if (in_valid_i) begin
        r_s1_last <= in_last_i;
        r_s1_mode <= mode_i;
        for (int p = 0; p < N_PAIRS; p++) begin
          r_s1_ps0[p] <= w_ps0[p];
          r_s1_ps1[p] <= w_ps1[p];
          r_s1_ca[p]  <= w_ca[p];
          r_s1_cb[p]  <= w_cb[p];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // S2: pair products, optional correction, reduction to one beat term
  // ---------------------------------------------------------------------------------------------
  logic signed [TermW-1:0] w_pair;
  logic signed [TermW-1:0] w_term;

  // Each pair value fits 2*PsW bits, so TermW-bit modular arithmetic stays exact.
  always_comb begin
    w_pair = '0;
    w_term = '0;
    for (int p = 0; p < N_PAIRS; p++) begin
      w_pair = TermW'(r_s1_ps0[p]) * TermW'(r_s1_ps1[p]);
      if (r_s1_mode) begin
        w_pair = w_pair - r_s1_ca[p] - r_s1_cb[p];
      end
      w_term = w_term + w_pair;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_term  <= '0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_last <= r_s1_last;
        r_s2_term <= w_term;
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // S3: group accumulation and result register
  // ---------------------------------------------------------------------------------------------
  logic signed [ACC_SIZE-1:0] w_term_ext;
  logic signed [ACC_SIZE-1:0] w_acc_sum;
  logic                       w_add_ovf;
  logic                       w_grp_ovf;
  logic [BEAT_W-1:0]          w_beats_inc;

  always_comb begin
    w_term_ext  = ACC_SIZE'(r_s2_term);
    w_acc_sum   = r_acc + w_term_ext;
    w_add_ovf   = (r_acc[ACC_SIZE-1] == w_term_ext[ACC_SIZE-1]) &&
                  (w_acc_sum[ACC_SIZE-1] != r_acc[ACC_SIZE-1]);
    w_grp_ovf   = r_ovf | w_add_ovf;
    w_beats_inc = (&r_beats) ? r_beats : r_beats + BEAT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_beats <= '0;
    end else if (w_en && r_s2_valid) begin
      if (r_s2_last) begin
        r_acc   <= '0;
        r_ovf   <= 1'b0;
        r_beats <= '0;
      end else begin
        r_acc   <= w_acc_sum;
        r_ovf   <= w_grp_ovf;
        r_beats <= w_beats_inc;
      end
    end
  end

  // With w_en high any held result is being consumed, so it may be replaced on this edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_out_ovf   <= 1'b0;
      r_out_beats <= '0;
    end else if (w_en) begin
      r_out_valid <= r_s2_valid && r_s2_last;
      if (r_s2_valid && r_s2_last) begin
        r_out       <= w_acc_sum;
        r_out_ovf   <= w_grp_ovf;
        r_out_beats <= w_beats_inc;
      end
    end
  end

endmodule

// File: tb/tb_winograd_dot_acc.sv
// Scoreboard bench for winograd_dot_acc: a 32-bit and a 20-bit accumulator instance share one
// stimulus stream; expected results are queued on acceptance of each last beat.
module tb_winograd_dot_acc;

  localparam int NE = 8;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                  rst_ni;
  logic                  in_valid_i;
  logic                  in_last_i;
  logic                  mode_i;
  logic                  out_ready_i;
  logic [0:NE-1][7:0]    in_0_i;
  logic [0:NE-1][7:0]    in_1_i;

  logic                  in_ready_o,  in_ready20;
  logic                  out_valid_o, out_valid20;
  logic [31:0]           out_o;
  logic [19:0]           out20;
  logic                  out_ovf_o,   ovf20;
  logic [15:0]           out_beats_o, beats20;

  winograd_dot_acc u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_0_i      (in_0_i),
    .in_1_i      (in_1_i),
    .in_last_i   (in_last_i),
    .mode_i      (mode_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_o       (out_o),
    .out_ovf_o   (out_ovf_o),
    .out_beats_o (out_beats_o)
  );

  winograd_dot_acc #(.ACC_SIZE(20)) u_dut20 (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready20),
    .in_0_i      (in_0_i),
    .in_1_i      (in_1_i),
    .in_last_i   (in_last_i),
    .mode_i      (mode_i),
    .out_valid_o (out_valid20),
    .out_ready_i (out_ready_i),
    .out_o       (out20),
    .out_ovf_o   (ovf20),
    .out_beats_o (beats20)
  );

  typedef struct {
    longint o32;
    bit     v32;
    longint o20;
    bit     v20;
    longint beats;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   mon_e;
  longint m_acc32, m_acc20;
  bit     m_ovf32, m_ovf20;
  int     m_beats;
  int     n_checks = 0;
  int     n_pass   = 0;
  bit     rnd_rdy  = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic longint wrapw(input longint x, input int w);
    longint m;
    m = x & ((longint'(1) << w) - 1);
    if (m[w-1]) m = m - (longint'(1) << w);
    return m;
  endfunction

  // Reference: RAW is the Winograd pair form, EXACT is the plain dot product.
  function automatic longint beat_term();
    longint t, a0, a1, b0, b1;
    t = 0;
    for (int p = 0; p < NE / 2; p++) begin
      a0 = longint'($signed(in_0_i[2*p]));
      a1 = longint'($signed(in_0_i[2*p+1]));
      b0 = longint'($signed(in_1_i[2*p]));
      b1 = longint'($signed(in_1_i[2*p+1]));
      if (mode_i) t += a0 * b0 + a1 * b1;
      else        t += (a1 + b0) * (a0 + b1);
    end
    return t;
  endfunction

  task automatic model_reset();
    m_acc32 = 0; m_acc20 = 0; m_ovf32 = 0; m_ovf20 = 0; m_beats = 0;
  endtask

  task automatic model_accept();
    longint t, s;
    exp_t   e;
    t = beat_term();
    s = wrapw(m_acc32 + t, 32);
    if (((m_acc32 < 0) == (t < 0)) && ((s < 0) != (m_acc32 < 0))) m_ovf32 = 1'b1;
    m_acc32 = s;
    s = wrapw(m_acc20 + t, 20);
    if (((m_acc20 < 0) == (t < 0)) && ((s < 0) != (m_acc20 < 0))) m_ovf20 = 1'b1;
    m_acc20 = s;
    m_beats++;
    if (in_last_i) begin
      e.o32 = m_acc32; e.v32 = m_ovf32; e.o20 = m_acc20; e.v20 = m_ovf20; e.beats = m_beats;
      sb_q.push_back(e);
      model_reset();
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    if (rnd_rdy) out_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    in_valid_i = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_beat(input bit last, input bit mode);
    bit ok;
    ok = 1'b0;
    in_valid_i = 1'b1;
    in_last_i  = last;
    mode_i     = mode;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_i);
      if (in_ready_o) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) check("accept_timeout", 0, 1);
    else begin
      model_accept();
      step();
    end
  endtask

  task automatic fill(input int av, input int bv);
    for (int i = 0; i < NE; i++) begin
      in_0_i[i] = 8'(av);
      in_1_i[i] = 8'(bv);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NE; i++) begin
      in_0_i[i] = 8'($urandom);
      in_1_i[i] = 8'($urandom);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, in_ready_o, 1);
    check({tag, "_out_valid"}, out_valid_o, 0);
    check({tag, "_out"}, out_o, 0);
    check({tag, "_ovf"}, out_ovf_o, 0);
    check({tag, "_beats"}, out_beats_o, 0);
  endtask

  always @(negedge clk_i) begin
    if (rst_ni && out_valid_o && out_ready_i) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("out32", longint'($signed(out_o)), mon_e.o32);
        check("ovf32", out_ovf_o, mon_e.v32);
        check("beats", out_beats_o, mon_e.beats);
        check("valid20", out_valid20, 1);
        check("out20", longint'($signed(out20)), mon_e.o20);
        check("ovf20", ovf20, mon_e.v20);
        check("beats20", beats20, mon_e.beats);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    in_last_i   = 1'b0;
    mode_i      = 1'b0;
    out_ready_i = 1'b1;
    fill(0, 0);
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_state("rst");
    rst_ni = 1'b1;
    step();

    // 1: EXACT single beat, latency two edges after accept
    fill(3, 2);
    send_beat(1'b1, 1'b1);
    in_valid_i = 1'b0;
    check("t1_lat_n1", out_valid_o, 0);
    step();
    check("t1_lat_n2", out_valid_o, 0);
    step();
    check("t1_lat_valid", out_valid_o, 1);
    check("t1_val", longint'($signed(out_o)), 48);
    idle(3);

    // 2: RAW single beat
    fill(3, 2);
    send_beat(1'b1, 1'b0);
    idle(4);
    check("t2_val", longint'($signed(out_o)), 100);

    // 3: three-beat EXACT group at the negative extreme
    fill(-128, -128);
    send_beat(1'b0, 1'b1);
    send_beat(1'b0, 1'b1);
    send_beat(1'b1, 1'b1);
    idle(4);
    check("t3_val", longint'($signed(out_o)), 393216);
    check("t3_beats", out_beats_o, 3);
    check("t3_ovf", out_ovf_o, 0);

    // 4: backpressure with a second group queued behind the pending result
    out_ready_i = 1'b0;
    fill(3, 2);
    send_beat(1'b1, 1'b1);
    fill(1, 1);
    send_beat(1'b1, 1'b1);
    in_valid_i = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("t4_in_ready", in_ready_o, 0);
      check("t4_valid", out_valid_o, 1);
      check("t4_hold", longint'($signed(out_o)), 48);
      step();
    end
    out_ready_i = 1'b1;
    idle(5);
    check("t4_next", longint'($signed(out_o)), 8);

    // 5: 20-bit accumulator wraps after four extreme beats
    fill(-128, -128);
    for (int i = 0; i < 4; i++) send_beat(i == 3, 1'b1);
    idle(4);
    check("t5_out20", longint'($signed(out20)), -524288);
    check("t5_ovf20", ovf20, 1);
    check("t5_out32", longint'($signed(out_o)), 524288);
    check("t5_ovf32", out_ovf_o, 0);
    fill(1, 1);
    send_beat(1'b1, 1'b1);
    idle(4);
    check("t5_next20", longint'($signed(out20)), 8);
    check("t5_next_ovf20", ovf20, 0);

    // 6: reset in the middle of an open group
    fill_rand();
    send_beat(1'b0, 1'b1);
    fill_rand();
    send_beat(1'b0, 1'b0);
    in_valid_i = 1'b0;
    rst_ni = 1'b0;
    model_reset();
    step();
    check_reset_state("t6_rst");
    step();
    rst_ni = 1'b1;
    step();
    fill(1, 1);
    send_beat(1'b1, 1'b1);
    idle(4);
    check("t6_val", longint'($signed(out_o)), 8);
    check("t6_beats", out_beats_o, 1);

    // Random groups, mixed modes, bubbles and random output backpressure
    rnd_rdy = 1'b1;
    for (int g = 0; g < 100; g++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        fill_rand();
        send_beat(b == len - 1, 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    rnd_rdy     = 1'b0;
    out_ready_i = 1'b1;
    in_valid_i  = 1'b0;
    for (int c = 0; c < 100 && sb_q.size() != 0; c++) step();
    check("drain_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
